// File: rtl/crg_rst_seq.sv
// -----------------------------------------------------------------------------
// crg_rst_seq
//
// Reset and clock-enable sequencer for the clock/reset generator. Runs on the
// free-running source clock. Holds the PLL in reset for a fixed time, waits
// for a filtered and synchronised PLL lock, then releases the per-domain
// resets one at a time, STAGE_GAP cycles apart. Once every domain is out of
// reset, the per-domain clock-buffer enables follow their requests.
//
// Lock loss while running: the enables drop at once. The domain resets stay
// released for STAGE_GAP cycles so in-flight logic can drain with its clocks
// stopped. Then all domains and the PLL go back into reset.
// Lock loss while releasing: everything goes straight back into reset, with no
// drain, because no clock enable was ever on.
//
// Ports
//   clk_src        in   1       free-running source clock (sole clock)
//   rst_n_sys      in   1       asynchronous active-low reset
//   pll_locked     in   1       PLL lock, asynchronous to clk_src
//   cen_req        in   NUM_CH  per-domain clock-enable request
//   pll_reset      out  1       active-high PLL reset
//   rst_n_ch       out  NUM_CH  per-domain active-low reset, bit i = domain i
//   cen_ch         out  NUM_CH  per-domain BUFGCE clock enable
//   seq_done       out  1       high only while running
//   lock_loss_cnt  out  8       saturating count of lock losses
//
// All outputs are registered; no input reaches an output combinationally.
// -----------------------------------------------------------------------------
module crg_rst_seq #(
    parameter int NUM_CH         = 4,
    parameter int PLL_RST_CYCLES = 4,
    parameter int LOCK_FILTER    = 16,
    parameter int STAGE_GAP      = 8,
    parameter int CNT_W          = 8
) (
    input  logic              clk_src,
    input  logic              rst_n_sys,
    input  logic              pll_locked,
    input  logic [NUM_CH-1:0] cen_req,
    output logic              pll_reset,
    output logic [NUM_CH-1:0] rst_n_ch,
    output logic [NUM_CH-1:0] cen_ch,
    output logic              seq_done,
    output logic [7:0]        lock_loss_cnt
);

    typedef enum logic [2:0] {
        S_PLL_RST,
        S_WAIT_LOCK,
        S_RELEASE,
        S_RUN,
        S_DRAIN
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;        // PLL reset timer, lock filter, stage gap, drain timer
    logic             lock_meta;
    logic             lock_s;

    localparam logic [CNT_W-1:0] PLL_RST_LAST = CNT_W'(PLL_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] FILTER_LAST  = CNT_W'(LOCK_FILTER - 1);
    localparam logic [CNT_W-1:0] GAP_LAST     = CNT_W'(STAGE_GAP - 1);

    // Two-flop synchroniser for the asynchronous lock signal. Resets to
    // "unlocked" so a stale lock can never skip the filter.
    always_ff @(posedge clk_src or negedge rst_n_sys) begin
        if (!rst_n_sys) begin
            lock_meta <= 1'b0;
            lock_s    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments make lock_s take the previous
            // lock_meta value; blocking ones would collapse the two stages.
            lock_meta <= pll_locked;
            lock_s    <= lock_meta;
        end
    end

    always_ff @(posedge clk_src or negedge rst_n_sys) begin
        if (!rst_n_sys) begin
            state         <= S_PLL_RST;
            cnt           <= '0;
            pll_reset     <= 1'b1;
            rst_n_ch      <= '0;
            cen_ch        <= '0;
            seq_done      <= 1'b0;
            lock_loss_cnt <= '0;
        end else begin
            case (state)
                S_PLL_RST: begin
                    if (cnt == PLL_RST_LAST) begin
                        state     <= S_WAIT_LOCK;
                        pll_reset <= 1'b0;
                        cnt       <= '0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end

                // cnt is the count of consecutive locked edges. Domain 0 is
                // released on the edge where that count reaches LOCK_FILTER.
                S_WAIT_LOCK: begin
                    if (!lock_s) begin
                        cnt <= '0;
                    end else if (cnt == FILTER_LAST) begin
                        state    <= S_RELEASE;
                        rst_n_ch <= NUM_CH'(1);
                        cnt      <= '0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end

                // rst_n_ch is a thermometer code: released domains fill up
                // from bit 0. When it is all ones, one more gap leads to RUN.
                S_RELEASE: begin
                    if (!lock_s) begin
                        state         <= S_PLL_RST;
                        rst_n_ch      <= '0;
                        pll_reset     <= 1'b1;
                        cnt           <= '0;
                        lock_loss_cnt <= (lock_loss_cnt == 8'hFF) ? lock_loss_cnt
                                                                  : lock_loss_cnt + 8'd1;
                    end else if (cnt == GAP_LAST) begin
                        cnt <= '0;
                        if (&rst_n_ch) begin
                            state    <= S_RUN;
                            seq_done <= 1'b1;
                        end else begin
                            rst_n_ch <= NUM_CH'({rst_n_ch, 1'b1});
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end

                // A lock loss takes priority over a simultaneous cen_req change.
                S_RUN: begin
                    if (!lock_s) begin
                        state         <= S_DRAIN;
                        cen_ch        <= '0;
                        seq_done      <= 1'b0;
                        cnt           <= '0;
                        lock_loss_cnt <= (lock_loss_cnt == 8'hFF) ? lock_loss_cnt
                                                                  : lock_loss_cnt + 8'd1;
                    end else begin
                        cen_ch <= cen_req;
                    end
                end

                // Lock returning here is deliberately ignored: the PLL is
                // restarted regardless, so the domains come back up cleanly.
                S_DRAIN: begin
                    if (cnt == GAP_LAST) begin
                        state     <= S_PLL_RST;
                        rst_n_ch  <= '0;
                        pll_reset <= 1'b1;
                        cnt       <= '0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end

                default: begin
                    state     <= S_PLL_RST;
                    rst_n_ch  <= '0;
                    cen_ch    <= '0;
                    seq_done  <= 1'b0;
                    pll_reset <= 1'b1;
                    cnt       <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_crg_rst_seq.sv
// -----------------------------------------------------------------------------
// tb_crg_rst_seq
//
// Directed bring-up, lock-loss and reset scenarios plus randomised lock/enable
// traffic for crg_rst_seq (NUM_CH=3, PLL_RST_CYCLES=3, LOCK_FILTER=4,
// STAGE_GAP=2). A timeline-based reference model derives every output from
// the phase in force and the edge at which that phase was entered.
// -----------------------------------------------------------------------------
module tb_crg_rst_seq;

    localparam int NC  = 3;
    localparam int PRC = 3;
    localparam int LF  = 4;
    localparam int SG  = 2;

    logic          clk_src = 1'b0;
    logic          rst_n_sys;
    logic          pll_locked;
    logic [NC-1:0] cen_req;
    logic          pll_reset;
    logic [NC-1:0] rst_n_ch;
    logic [NC-1:0] cen_ch;
    logic          seq_done;
    logic [7:0]    lock_loss_cnt;

    int checks   = 0;
    int failures = 0;

    crg_rst_seq #(
        .NUM_CH        (NC),
        .PLL_RST_CYCLES(PRC),
        .LOCK_FILTER   (LF),
        .STAGE_GAP     (SG),
        .CNT_W         (8)
    ) dut (
        .clk_src      (clk_src),
        .rst_n_sys    (rst_n_sys),
        .pll_locked   (pll_locked),
        .cen_req      (cen_req),
        .pll_reset    (pll_reset),
        .rst_n_ch     (rst_n_ch),
        .cen_ch       (cen_ch),
        .seq_done     (seq_done),
        .lock_loss_cnt(lock_loss_cnt)
    );

    always #5 clk_src = ~clk_src;

    // ---------------- reference model ----------------
    typedef enum int {M_PLL_RST, M_WAIT, M_REL, M_RUN, M_DRAIN} mphase_t;

    mphase_t       ph;
    int            n;       // edges since reset release
    int            t0;      // edge at which the current phase was entered
    int            run;     // consecutive locked edges seen while waiting
    bit            s1, s2;  // lock as seen one and two edges later
    logic [NC-1:0] m_cen;
    int            m_loss;

    task automatic model_reset();
        ph = M_PLL_RST; n = 0; t0 = 0; run = 0;
        s1 = 1'b0; s2 = 1'b0; m_cen = '0; m_loss = 0;
    endtask

    task automatic model_step(input logic p, input logic [NC-1:0] c);
        bit ls;
        ls = s2;
        s2 = s1;
        s1 = p;
        n++;
        case (ph)
            M_PLL_RST: if (n - t0 == PRC) begin ph = M_WAIT; t0 = n; run = 0; end
            M_WAIT: begin
                run = ls ? run + 1 : 0;
                if (run == LF) begin ph = M_REL; t0 = n; end
            end
            M_REL: begin
                if (!ls) begin
                    ph = M_PLL_RST; t0 = n;
                    if (m_loss < 255) m_loss++;
                end else if (n - t0 == NC * SG) begin
                    ph = M_RUN; t0 = n; m_cen = '0;
                end
            end
            M_RUN: begin
                if (!ls) begin
                    ph = M_DRAIN; t0 = n; m_cen = '0;
                    if (m_loss < 255) m_loss++;
                end else begin
                    m_cen = c;
                end
            end
            M_DRAIN: if (n - t0 == SG) begin ph = M_PLL_RST; t0 = n; end
            default: ph = M_PLL_RST;
        endcase
    endtask

    function automatic logic [NC-1:0] exp_rst();
        int k;
        case (ph)
            M_REL: begin
                k = 1 + (n - t0) / SG;
                if (k > NC) k = NC;
                return NC'((1 << k) - 1);
            end
            M_RUN, M_DRAIN: return '1;
            default:        return '0;
        endcase
    endfunction

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic compare_all();
        check("pll_reset",     16'(pll_reset),     16'(ph == M_PLL_RST));
        check("rst_n_ch",      16'(rst_n_ch),      16'(exp_rst()));
        check("cen_ch",        16'(cen_ch),        16'((ph == M_RUN) ? m_cen : '0));
        check("seq_done",      16'(seq_done),      16'(ph == M_RUN));
        check("lock_loss_cnt", 16'(lock_loss_cnt), 16'(m_loss));
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_pll_reset"}, 16'(pll_reset),     16'(1));
        check({tag, "_rst_n_ch"},  16'(rst_n_ch),      16'(0));
        check({tag, "_cen_ch"},    16'(cen_ch),        16'(0));
        check({tag, "_seq_done"},  16'(seq_done),      16'(0));
        check({tag, "_loss_cnt"},  16'(lock_loss_cnt), 16'(0));
    endtask

    // One rising edge: model sees the same inputs the DUT samples, then
    // outputs are compared at the falling edge.
    task automatic tick();
        @(posedge clk_src);
        model_step(pll_locked, cen_req);
        @(negedge clk_src);
        compare_all();
    endtask

    task automatic timeout(input string tag);
        checks++;
        failures++;
        $error("FAIL timeout_%s: observed no progress, expected phase change", tag);
    endtask

    initial begin
        int drop_left;
        int guard;

        rst_n_sys  = 1'b0;
        pll_locked = 1'b1;
        cen_req    = 3'b111;
        model_reset();
        repeat (2) @(negedge clk_src);
        check_reset_values("por");
        rst_n_sys = 1'b1;

        // Clean bring-up with absolute cycle numbers.
        for (int cyc = 1; cyc <= 14; cyc++) begin
            tick();
            case (cyc)
                2:  check("up_pll_reset_c2", 16'(pll_reset), 16'(1));
                3:  check("up_pll_reset_c3", 16'(pll_reset), 16'(0));
                6:  check("up_rst_c6",  16'(rst_n_ch), 16'(3'b000));
                7:  check("up_rst_c7",  16'(rst_n_ch), 16'(3'b001));
                8:  check("up_rst_c8",  16'(rst_n_ch), 16'(3'b001));
                9:  check("up_rst_c9",  16'(rst_n_ch), 16'(3'b011));
                11: check("up_rst_c11", 16'(rst_n_ch), 16'(3'b111));
                12: check("up_done_c12", 16'(seq_done), 16'(0));
                13: begin
                    check("up_done_c13", 16'(seq_done), 16'(1));
                    check("up_cen_c13",  16'(cen_ch),   16'(3'b000));
                end
                14: check("up_cen_c14", 16'(cen_ch), 16'(3'b111));
                default: ;
            endcase
        end

        // Enable requests in RUN, one-cycle latency.
        cen_req = 3'b101;
        tick();
        check("cen_101", 16'(cen_ch), 16'(3'b101));
        cen_req = 3'b010;
        tick();
        check("cen_010", 16'(cen_ch), 16'(3'b010));

        // One-cycle lock drop in RUN; its return during the drain is ignored.
        pll_locked = 1'b0;
        tick();
        pll_locked = 1'b1;
        cen_req    = 3'b111;
        tick();
        tick();
        check("run_loss_cen",  16'(cen_ch),        16'(0));
        check("run_loss_done", 16'(seq_done),      16'(0));
        check("run_loss_cnt",  16'(lock_loss_cnt), 16'(1));
        tick();
        check("drain_rst_hold", 16'(rst_n_ch),  16'(3'b111));
        check("drain_pll_low",  16'(pll_reset), 16'(0));
        tick();
        check("drain_end_rst", 16'(rst_n_ch),  16'(3'b000));
        check("drain_end_pll", 16'(pll_reset), 16'(1));
        repeat (3) tick();
        check("reseq_pll_fall", 16'(pll_reset), 16'(0));

        // Lock loss in RELEASE right after domain 0 is out of reset.
        repeat (2) tick();
        pll_locked = 1'b0;
        repeat (2) tick();
        check("rel_only_ch0", 16'(rst_n_ch), 16'(3'b001));
        tick();
        check("rel_loss_rst", 16'(rst_n_ch),      16'(3'b000));
        check("rel_loss_pll", 16'(pll_reset),     16'(1));
        check("rel_loss_cnt", 16'(lock_loss_cnt), 16'(2));
        pll_locked = 1'b1;
        repeat (3) tick();
        check("rel_restart_pll_fall", 16'(pll_reset), 16'(0));

        // Filter glitch while the filter count is 3.
        tick();
        pll_locked = 1'b0;
        tick();
        pll_locked = 1'b1;
        repeat (5) tick();
        check("glitch_not_yet", 16'(rst_n_ch), 16'(3'b000));
        tick();
        check("glitch_release", 16'(rst_n_ch), 16'(3'b001));

        // Randomised lock drops and enable requests.
        drop_left = 0;
        for (int i = 0; i < 600; i++) begin
            cen_req = NC'($urandom);
            if (drop_left > 0) begin
                pll_locked = 1'b0;
                drop_left--;
            end else begin
                pll_locked = 1'b1;
                if ($urandom_range(0, 59) == 0) drop_left = $urandom_range(1, 3);
            end
            tick();
        end

        // Get to RUN with enables on, then pulse reset mid-cycle.
        pll_locked = 1'b1;
        cen_req    = 3'b111;
        guard      = 0;
        while (ph != M_RUN && guard < 60) begin tick(); guard++; end
        if (ph != M_RUN) timeout("reach_run");
        tick();
        #2 rst_n_sys = 1'b0;
        #1 check_reset_values("mid");
        @(negedge clk_src);
        rst_n_sys = 1'b1;
        model_reset();

        // 256 lock losses in RELEASE to saturate the counter.
        for (int l = 0; l < 256; l++) begin
            pll_locked = 1'b1;
            guard = 0;
            while (ph != M_REL && guard < 60) begin tick(); guard++; end
            if (ph != M_REL) timeout("reach_release");
            pll_locked = 1'b0;
            guard = 0;
            while (ph != M_PLL_RST && guard < 20) begin tick(); guard++; end
            if (ph != M_PLL_RST) timeout("reach_pll_rst");
        end
        check("loss_saturated", 16'(lock_loss_cnt), 16'(255));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
